// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the clock-divider bank.
package clkdiv_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 16;
  localparam int SEL_W      = 4;

  // Reset divide value for channel idx: 2, 4, 8, 16, ... (caller truncates to CNT_W).
  function automatic logic [31:0] rst_div(input int unsigned idx);
    return 32'd1 << (idx + 1);
  endfunction

endpackage

// File: rtl/clkdiv_if.sv
// Divide-value load bus shared by all channels.
interface clkdiv_if
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  // Strobe-only bus: div_load is a one-cycle write qualifier with no ready;
  // the bank accepts (or silently drops, for an out-of-range div_sel) every strobe.
  logic             div_load;
  logic [SEL_W-1:0] div_sel;
  logic [CNT_W-1:0] div_val;

  modport master (output div_load, div_sel, div_val);
  modport slave  (input  div_load, div_sel, div_val);
endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: active/shadow divide values, counter, and registered outputs.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] val,
  output logic             clk_out,
  output logic             tick
);
  logic [CNT_W-1:0] d, s, cnt;
  logic             p;
  logic [CNT_W-1:0] d_nx, s_nx, cnt_nx, d_eff, d_nx_eff, val_n;
  logic             p_nx, tick_nx, clk_out_nx, wrap;

  localparam logic [CNT_W-1:0] RST_D = CNT_W'(rst_div(IDX));
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  always_comb begin
    val_n  = (val == '0) ? ONE : val;
    d_eff  = (d == '0) ? ONE : d;
    wrap   = en && (cnt == d_eff - ONE);
    d_nx   = d;
    s_nx   = s;
    p_nx   = p;
    cnt_nx = cnt;
    tick_nx = 1'b0;
    if (sync) begin
      // Sync realigns everyone; a coinciding load goes straight to the active value.
      cnt_nx = '0;
      p_nx   = 1'b0;
      if (load)   d_nx = val_n;
      else if (p) d_nx = s;
    end else if (load && !en) begin
      d_nx   = val_n;
      cnt_nx = '0;
      p_nx   = 1'b0;
    end else if (en) begin
      tick_nx = wrap;
      if (wrap) begin
        cnt_nx = '0;
        // A load landing on the wrap edge is newer than any shadow value.
        if (load) begin
          d_nx = val_n;
          s_nx = val_n;
          p_nx = 1'b0;
        end else if (p) begin
          d_nx = s;
          p_nx = 1'b0;
        end
      end else begin
        cnt_nx = cnt + ONE;
        if (load) begin
          s_nx = val_n;
          p_nx = 1'b1;
        end
      end
    end
    d_nx_eff   = (d_nx == '0) ? ONE : d_nx;
    clk_out_nx = (cnt_nx >= (d_nx_eff >> 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d       <= RST_D;
      s       <= RST_D;
      p       <= 1'b0;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      d       <= d_nx;
      s       <= s_nx;
      p       <= p_nx;
      cnt     <= cnt_nx;
      clk_out <= clk_out_nx;
      tick    <= tick_nx;
    end
  end

endmodule

// File: rtl/clkdiv_bank.sv
// Bank of NUM_CH independent clock dividers sharing one load bus and a sync pulse.
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  clkdiv_if.slave           ld,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  logic [NUM_CH-1:0] load_ch;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Indices >= NUM_CH match no channel, so such loads are dropped.
    assign load_ch[i] = ld.div_load && (ld.div_sel == SEL_W'(i));

    clkdiv_chan #(.CNT_W(CNT_W), .IDX(i)) u_chan (
      .clk     (clk),
      .reset   (reset),
      .en      (en[i]),
      .sync    (sync),
      .load    (load_ch[i]),
      .val     (ld.div_val),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_clkdiv_bank;
  import clkdiv_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] en = '0;
  logic              sync = 1'b0;
  logic [NUM_CH-1:0] clk_out, tick;

  clkdiv_if #(.CNT_W(CNT_W)) lb ();

  clkdiv_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sync    (sync),
    .ld      (lb.slave),
    .clk_out (clk_out),
    .tick    (tick)
  );

  // clock / reset
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model: divide ratio, shadow, pending, phase within period
  int unsigned m_d[NUM_CH], m_s[NUM_CH], m_cnt[NUM_CH];
  bit          m_p[NUM_CH];
  logic [NUM_CH-1:0] m_co, m_tk;
  logic [2*NUM_CH-1:0] exp_q[$];
  int tk_count[NUM_CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int unsigned fix(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_step();
    for (int i = 0; i < NUM_CH; i++) begin
      bit ld = lb.div_load && (int'(lb.div_sel) == i);
      int unsigned v = fix(int'(lb.div_val));
      m_tk[i] = 1'b0;
      if (reset) begin
        m_d[i] = fix(int'((64'd1 << (i + 1)) % (64'd1 << CNT_W)));
        m_s[i] = m_d[i];
        m_p[i] = 0;
        m_cnt[i] = 0;
      end else if (sync) begin
        m_cnt[i] = 0;
        if (ld) m_d[i] = v;
        else if (m_p[i]) m_d[i] = m_s[i];
        m_p[i] = 0;
      end else if (ld && !en[i]) begin
        m_d[i] = v;
        m_cnt[i] = 0;
        m_p[i] = 0;
      end else if (en[i]) begin
        m_cnt[i] = (m_cnt[i] + 1) % m_d[i];
        if (m_cnt[i] == 0) begin
          m_tk[i] = 1'b1;
          if (ld) begin m_d[i] = v; m_p[i] = 0; end
          else if (m_p[i]) begin m_d[i] = m_s[i]; m_p[i] = 0; end
        end else if (ld) begin
          m_s[i] = v;
          m_p[i] = 1;
        end
      end
      m_co[i] = reset ? 1'b0 : (m_cnt[i] >= m_d[i] / 2);
    end
  endtask

  // driver: one clock with current inputs, then scoreboard compare
  task automatic cycle();
    logic [2*NUM_CH-1:0] e;
    model_step();
    exp_q.push_back({m_tk, m_co});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("clk_out", 32'(clk_out), 32'(e[NUM_CH-1:0]));
    chk("tick", 32'(tick), 32'(e[2*NUM_CH-1:NUM_CH]));
    for (int i = 0; i < NUM_CH; i++) tk_count[i] += int'(tick[i]);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic load(input int sel, input int val);
    lb.div_load = 1'b1;
    lb.div_sel  = SEL_W'(sel);
    lb.div_val  = CNT_W'(val);
    cycle();
    lb.div_load = 1'b0;
  endtask

  initial begin
    lb.div_load = 1'b0;
    lb.div_sel  = '0;
    lb.div_val  = '0;
    reset = 1'b1;
    en = 4'b1111;
    run(2);
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);

    // Scenario 1: free-running reset dividers
    reset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) tk_count[i] = 0;
    run(32);
    for (int i = 0; i < NUM_CH; i++) chk($sformatf("s1_ticks_ch%0d", i), tk_count[i], 32 >> (i + 1));

    // Scenario 2: mid-period load of D=3 on running ch0 (cnt 0 of 2 is not a wrap edge)
    for (int k = 0; k < 4 && m_cnt[0] != 0; k++) cycle();
    load(0, 3);
    run(12);

    // Scenario 3: D=0 then D=1 into disabled ch1, then enable
    en[1] = 1'b0;
    run(2);
    load(1, 0);
    load(1, 1);
    en[1] = 1'b1;
    run(2);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("s3_clk_out1", 32'(clk_out[1]), 32'h1);
      chk("s3_tick1", 32'(tick[1]), 32'h1);
    end

    // Scenario 4: sync while ch2 sits at count 5 of 8
    for (int k = 0; k < 16 && m_cnt[2] != 5; k++) cycle();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    chk("s4_tick_after_sync", 32'(tick), 32'h0);
    run(48);

    // Scenario 5: load on ch3's wrap edge, and an out-of-range select
    for (int k = 0; k < 32 && m_cnt[3] != m_d[3] - 1; k++) cycle();
    load(3, 5);
    run(12);
    load(7, 9);
    run(20);

    // Scenario 6: pending load on ch0 discarded by reset
    for (int k = 0; k < 8 && (m_cnt[0] == m_d[0] - 1); k++) cycle();
    load(0, 6);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) tk_count[i] = 0;
    run(16);
    chk("s6_ch0_ticks", tk_count[0], 8);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      en = NUM_CH'($urandom) | NUM_CH'($urandom);
      sync = ($urandom_range(0, 39) == 0);
      lb.div_load = ($urandom_range(0, 5) == 0);
      lb.div_sel  = SEL_W'($urandom_range(0, 7));
      lb.div_val  = CNT_W'($urandom_range(0, 9));
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    lb.div_load = 1'b0;
    sync = 1'b0;
    reset = 1'b0;
    en = '1;
    run(20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
